// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main controller for the multicycle MIPS-subset datapath.
// Steps one instruction at a time through fetch, decode, execute, memory
// and writeback. It drives every datapath select, write enable and the ALU
// function code from the current step and the instruction's op/funct fields.
module multicycle_ctrl #(
   parameter bit FUNCT_CHECK = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [2:0] alucontrol,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       iord,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic       instr_done,
   output logic       illegal
);

   // controller steps
   localparam logic [3:0] FETCH   = 4'd0;
   localparam logic [3:0] DECODE  = 4'd1;
   localparam logic [3:0] MEMADR  = 4'd2;
   localparam logic [3:0] MEMRD   = 4'd3;
   localparam logic [3:0] MEMWB   = 4'd4;
   localparam logic [3:0] MEMWR   = 4'd5;
   localparam logic [3:0] EXECUTE = 4'd6;
   localparam logic [3:0] ALUWB   = 4'd7;
   localparam logic [3:0] BEQEX   = 4'd8;
   localparam logic [3:0] ADDIEX  = 4'd9;
   localparam logic [3:0] ADDIWB  = 4'd10;
   localparam logic [3:0] JEX     = 4'd11;

   // aluop of 00 means "add", so every step that does not care about the
   // ALU still presents a harmless ADD to the datapath
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   logic [3:0] state;
   logic [3:0] nextstate;
   logic [1:0] aluop;
   logic       pcwrite;
   logic       branch;
   logic       functok;
   logic       badinstr;

   // recognise the R-type funct codes the ALU decode supports
   always_comb begin
      functok = 1'b0;
      case (funct)
         6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: functok = 1'b1;
         default:                                                functok = 1'b0;
      endcase
   end

   // flag opcodes (and optionally R-type functs) this controller cannot run
   always_comb begin
      badinstr = 1'b1;
      case (op)
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: badinstr = 1'b0;
         OP_RTYPE:                            badinstr = FUNCT_CHECK && !functok;
         default:                             badinstr = 1'b1;
      endcase
   end

   // state register; reset aborts any instruction in flight
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= nextstate;
   end

   // step sequencing; unused encodings fall back to FETCH
   always_comb begin
      nextstate = FETCH;
      case (state)
         FETCH:  nextstate = DECODE;
         DECODE: begin
            if (badinstr) nextstate = FETCH;
            else begin
               case (op)
                  OP_LW, OP_SW: nextstate = MEMADR;
                  OP_RTYPE:     nextstate = EXECUTE;
                  OP_BEQ:       nextstate = BEQEX;
                  OP_ADDI:      nextstate = ADDIEX;
                  OP_J:         nextstate = JEX;
                  default:      nextstate = FETCH;
               endcase
            end
         end
         MEMADR:  nextstate = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   nextstate = MEMWB;
         MEMWB:   nextstate = FETCH;
         MEMWR:   nextstate = FETCH;
         EXECUTE: nextstate = ALUWB;
         ALUWB:   nextstate = FETCH;
         BEQEX:   nextstate = FETCH;
         ADDIEX:  nextstate = ADDIWB;
         ADDIWB:  nextstate = FETCH;
         JEX:     nextstate = FETCH;
         default: nextstate = FETCH;
      endcase
   end

   // per-step datapath controls; while reset is high the selects show FETCH
   // values and every enable stays low so an aborted instruction writes nothing
   always_comb begin
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      iord       = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      pcsrc      = 2'b00;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      aluop      = ALUOP_ADD;
      if (reset) begin
         alusrcb = 2'b01;
      end else begin
         case (state)
            FETCH: begin
               alusrcb = 2'b01;
               irwrite = 1'b1;
               pcwrite = 1'b1;
            end
            DECODE: begin
               alusrcb = 2'b11;
               illegal = badinstr;
            end
            MEMADR: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
            end
            MEMRD: begin
               iord = 1'b1;
            end
            MEMWB: begin
               memtoreg   = 1'b1;
               regwrite   = 1'b1;
               instr_done = 1'b1;
            end
            MEMWR: begin
               iord       = 1'b1;
               memwrite   = 1'b1;
               instr_done = 1'b1;
            end
            EXECUTE: begin
               alusrca = 1'b1;
               aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
               regdst     = 1'b1;
               regwrite   = 1'b1;
               instr_done = 1'b1;
            end
            BEQEX: begin
               alusrca    = 1'b1;
               aluop      = ALUOP_SUB;
               pcsrc      = 2'b01;
               branch     = 1'b1;
               instr_done = 1'b1;
            end
            ADDIEX: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
            end
            ADDIWB: begin
               regwrite   = 1'b1;
               instr_done = 1'b1;
            end
            JEX: begin
               pcsrc      = 2'b10;
               pcwrite    = 1'b1;
               instr_done = 1'b1;
            end
            default: begin
               alusrcb = 2'b00;
            end
         endcase
      end
   end

   // branch is only ever high in BEQEX, so zero has no effect anywhere else
   assign pcen = !reset && (pcwrite || (branch && zero));

   // ALU function from aluop, falling back to ADD for unknown R-type functs
   always_comb begin
      alucontrol = 3'b010;
      case (aluop)
         ALUOP_ADD: alucontrol = 3'b010;
         ALUOP_SUB: alucontrol = 3'b110;
         ALUOP_FUNCT: begin
            case (funct)
               6'b100000: alucontrol = 3'b010;
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default:   alucontrol = 3'b010;
            endcase
         end
         default: alucontrol = 3'b010;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized instruction streams for the
// multicycle controller, compared every cycle against an instruction-level
// model of which controls each cycle of each instruction must show.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic [2:0] alucontrol;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       iord;
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic [1:0] pcsrc;
      logic       pcen;
      logic       instrDone;
      logic       illegal;
   } outVec_t;

   localparam int C_LW   = 0;
   localparam int C_SW   = 1;
   localparam int C_RT   = 2;
   localparam int C_BEQ  = 3;
   localparam int C_ADDI = 4;
   localparam int C_J    = 5;
   localparam int C_ILL  = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'b100011;
   logic [5:0] funct = 6'b0;
   logic       zero = 1'b0;
   logic [2:0] alucontrol;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic       iord;
   logic       irwrite;
   logic       memwrite;
   logic       regwrite;
   logic       regdst;
   logic       memtoreg;
   logic [1:0] pcsrc;
   logic       pcen;
   logic       instr_done;
   logic       illegal;

   outVec_t dutVec;
   outVec_t snap;
   outVec_t snapLog [0:7];
   outVec_t expQ [$];
   int      tagQ [$];
   int      errors = 0;
   int      checks = 0;
   int      instrCount = 0;

   multicycle_ctrl #(.FUNCT_CHECK(1'b1)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb),
      .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
      .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
      .pcsrc(pcsrc), .pcen(pcen), .instr_done(instr_done), .illegal(illegal)
   );

   assign dutVec = {alucontrol, alusrca, alusrcb, iord, irwrite, memwrite,
                    regwrite, regdst, memtoreg, pcsrc, pcen, instr_done, illegal};

   // free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic int latencyOf(input int cls);
      case (cls)
         C_LW:               return 5;
         C_SW, C_RT, C_ADDI: return 4;
         C_BEQ, C_J:         return 3;
         default:            return 2;
      endcase
   endfunction

   function automatic bit functSupported(input logic [5:0] fn);
      return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
             fn == 6'b100101 || fn == 6'b101010;
   endfunction

   function automatic logic [2:0] aluForFunct(input logic [5:0] fn);
      case (fn)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic outVec_t resetVec();
      outVec_t v = '0;
      v.alucontrol = 3'b010;
      v.alusrcb    = 2'b01;
      return v;
   endfunction

   // what cycle k of an instruction of class cls must drive; every cycle
   // that does not use the ALU still presents ADD
   function automatic outVec_t modelCycle(input int cls, input int k, input logic z, input logic [5:0] fn);
      outVec_t v = '0;
      v.alucontrol = 3'b010;
      if (k == 0) begin
         v.alusrcb = 2'b01;
         v.irwrite = 1'b1;
         v.pcen    = 1'b1;
      end else if (k == 1) begin
         v.alusrcb = 2'b11;
         v.illegal = (cls == C_ILL);
      end else begin
         case (cls)
            C_LW, C_SW, C_ADDI: begin
               if (k == 2) begin
                  v.alusrca = 1'b1;
                  v.alusrcb = 2'b10;
               end else if (cls == C_LW && k == 3) begin
                  v.iord = 1'b1;
               end else if (cls == C_LW) begin
                  v.memtoreg = 1'b1;
                  v.regwrite = 1'b1;
               end else if (cls == C_SW) begin
                  v.iord     = 1'b1;
                  v.memwrite = 1'b1;
               end else begin
                  v.regwrite = 1'b1;
               end
            end
            C_RT: begin
               if (k == 2) begin
                  v.alusrca    = 1'b1;
                  v.alucontrol = aluForFunct(fn);
               end else begin
                  v.regdst   = 1'b1;
                  v.regwrite = 1'b1;
               end
            end
            C_BEQ: begin
               v.alusrca    = 1'b1;
               v.alucontrol = 3'b110;
               v.pcsrc      = 2'b01;
               v.pcen       = z;
            end
            C_J: begin
               v.pcsrc = 2'b10;
               v.pcen  = 1'b1;
            end
            default: v = v;
         endcase
      end
      if (cls != C_ILL && k == latencyOf(cls) - 1) v.instrDone = 1'b1;
      return v;
   endfunction

   // one clock of stimulus: drive inputs, queue the expectation, snapshot outputs
   task automatic applyStimulus(input logic rst, input logic [5:0] opv, input logic [5:0] fnv,
                                input logic z, input outVec_t exp, input int tag);
      reset = rst;
      op    = opv;
      funct = fnv;
      zero  = z;
      expQ.push_back(exp);
      tagQ.push_back(tag);
      #3;
      snap = dutVec;
      @(posedge clk);
      #1;
   endtask

   // run one instruction; zeroSel 0/1 holds zero fixed, 2 randomizes it per cycle;
   // abortAt is the cycle at which reset is pulsed (-1 for none)
   task automatic runInstr(input int cls, input logic [5:0] opv, input logic [5:0] fnv,
                           input int zeroSel, input int abortAt);
      int   lat;
      logic z;
      lat = latencyOf(cls);
      instrCount++;
      for (int k = 0; k < lat; k++) begin
         z = (zeroSel == 2) ? 1'($urandom_range(0, 1)) : 1'(zeroSel);
         if (k == abortAt) begin
            applyStimulus(1'b1, opv, fnv, z, resetVec(), instrCount * 16 + k);
            snapLog[k] = snap;
            break;
         end
         applyStimulus(1'b0, opv, fnv, z, modelCycle(cls, k, z, fnv), instrCount * 16 + k);
         snapLog[k] = snap;
      end
   endtask

   // compare every meaningful cycle against the queued model expectation
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         outVec_t e;
         int      t;
         e = expQ.pop_front();
         t = tagQ.pop_front();
         checkOutput($sformatf("cycle instr%0d/step%0d", t / 16, t % 16), 32'(dutVec), 32'(e));
      end
   end

   function automatic logic [5:0] opForClass(input int cls);
      case (cls)
         C_LW:    return 6'b100011;
         C_SW:    return 6'b101011;
         C_RT:    return 6'b000000;
         C_BEQ:   return 6'b000100;
         C_ADDI:  return 6'b001000;
         default: return 6'b000010;
      endcase
   endfunction

   initial begin
      int          doneCount;
      int          cls;
      int          abortAt;
      logic [5:0]  opv;
      logic [5:0]  fnv;
      logic [5:0]  goodFuncts [0:4];
      goodFuncts = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

      $display("[TB] start");
      @(posedge clk);
      #1;

      // reset held for two cycles with an lw opcode present
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 6'b100011, 6'b0, 1'b1, resetVec(), i);
         checkOutput($sformatf("reset enables c%0d", i),
                     32'({snap.irwrite, snap.memwrite, snap.regwrite, snap.pcen}), 32'd0);
      end

      // lw: five cycles, writeback only at the end, a single retire pulse
      runInstr(C_LW, 6'b100011, 6'b0, 2, -1);
      checkOutput("lw fetch irwrite/pcen", 32'({snapLog[0].irwrite, snapLog[0].pcen}), 32'd3);
      checkOutput("lw fetch alucontrol", 32'(snapLog[0].alucontrol), 32'd2);
      checkOutput("lw memrd regwrite", 32'(snapLog[3].regwrite), 32'd0);
      checkOutput("lw memwb memtoreg/regwrite", 32'({snapLog[4].memtoreg, snapLog[4].regwrite}), 32'd3);
      doneCount = 0;
      for (int k = 0; k < 5; k++) doneCount += int'(snapLog[k].instrDone);
      checkOutput("lw retire count", 32'(doneCount), 32'd1);

      // R-type slt then and
      runInstr(C_RT, 6'b000000, 6'b101010, 2, -1);
      checkOutput("slt alucontrol", 32'(snapLog[2].alucontrol), 32'd7);
      checkOutput("slt regdst", 32'(snapLog[3].regdst), 32'd1);
      runInstr(C_RT, 6'b000000, 6'b100100, 2, -1);
      checkOutput("and alucontrol", 32'(snapLog[2].alucontrol), 32'd0);

      // beq taken then not taken
      runInstr(C_BEQ, 6'b000100, 6'b0, 1, -1);
      checkOutput("beq alucontrol", 32'(snapLog[2].alucontrol), 32'd6);
      checkOutput("beq pcsrc", 32'(snapLog[2].pcsrc), 32'd1);
      checkOutput("beq taken pcen", 32'(snapLog[2].pcen), 32'd1);
      runInstr(C_BEQ, 6'b000100, 6'b0, 0, -1);
      checkOutput("beq untaken pcen", 32'(snapLog[2].pcen), 32'd0);
      checkOutput("beq untaken retire", 32'(snapLog[2].instrDone), 32'd1);

      // unknown opcode, then R-type with unsupported funct
      runInstr(C_ILL, 6'b111111, 6'b0, 2, -1);
      checkOutput("bad op illegal", 32'(snapLog[1].illegal), 32'd1);
      runInstr(C_ILL, 6'b000000, 6'b000011, 2, -1);
      checkOutput("bad funct illegal", 32'(snapLog[1].illegal), 32'd1);
      checkOutput("bad funct enables", 32'({snapLog[1].regwrite, snapLog[1].memwrite, snapLog[1].irwrite}), 32'd0);

      // sw aborted by reset in its memory-write cycle, followed by a clean j
      runInstr(C_SW, 6'b101011, 6'b0, 2, 3);
      checkOutput("sw abort memwrite", 32'(snapLog[3].memwrite), 32'd0);
      runInstr(C_J, 6'b000010, 6'b0, 2, -1);
      checkOutput("j after abort fetch irwrite", 32'(snapLog[0].irwrite), 32'd1);

      // randomized instruction stream with occasional mid-instruction resets
      for (int n = 0; n < 400; n++) begin
         cls = $urandom_range(0, 6);
         fnv = 6'($urandom_range(0, 63));
         opv = opForClass(cls);
         if (cls == C_RT) begin
            if ($urandom_range(0, 5) != 0) fnv = goodFuncts[$urandom_range(0, 4)];
            else if (functSupported(fnv)) fnv = 6'b000011;
            if (!functSupported(fnv)) cls = C_ILL;
         end else if (cls == C_ILL) begin
            opv = 6'($urandom_range(0, 63));
            if (opv == 6'b000000 || opv == 6'b000010 || opv == 6'b000100 ||
                opv == 6'b001000 || opv == 6'b100011 || opv == 6'b101011)
               opv = 6'b111111;
         end
         abortAt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, latencyOf(cls) - 1) : -1;
         runInstr(cls, opv, fnv, 2, abortAt);
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
